// File: rtl/pack_stable_synchronizer.sv
// Brings an asynchronous bus into the CLK domain, accepts a word only once it has been steady,
// counts abandoned candidates, and optionally packs two accepted words per output.
module pack_stable_synchronizer #(
  parameter int WIDTH         = 13,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 3,
  parameter int PACK          = 1,
  parameter int GLITCH_W      = 16
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic [WIDTH-1:0]            ASYNC_IN,
  input  logic                        ENABLE,
  output logic [(PACK+1)*WIDTH-1:0]   SYNC_OUT,
  output logic                        SYNC_VALID,
  output logic                        PHASE,
  output logic [GLITCH_W-1:0]         GLITCH_COUNT
);

  localparam int CNT_W = (STABLE_CYCLES < 1) ? 1 : $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0]    p_q;
  logic [WIDTH-1:0]    acc_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [GLITCH_W-1:0] glitch_q, glitch_d;
  logic [WIDTH-1:0]    s;
  logic                accept;
  logic                glitch;

  function automatic logic [GLITCH_W-1:0] sat_inc(input logic [GLITCH_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign s = sync_q[SYNC_STAGES-1];

  // Stage boundary: metastability chain into the CLK domain
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= ASYNC_IN;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Acceptance fires on the edge where the count reaches saturation, so the output
  // registers at edge SYNC_STAGES+STABLE_CYCLES; saturated words wait for ENABLE.
  always_comb begin
    cnt_d    = cnt_q;
    glitch_d = glitch_q;
    if (s != p_q)              cnt_d = '0;
    else if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    accept = ENABLE && (s == p_q) && (cnt_d == CNT_MAX) && (s != acc_q);
    glitch = (s != p_q) && (p_q != acc_q) && (cnt_q < CNT_MAX);
    if (glitch) glitch_d = sat_inc(glitch_q);
  end

  // Stage boundary: qualification state
  always_ff @(posedge CLK) begin
    if (RESET) begin
      p_q      <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      glitch_q <= '0;
    end else begin
      p_q      <= s;
      cnt_q    <= cnt_d;
      glitch_q <= glitch_d;
      if (accept) acc_q <= s;
    end
  end

  assign GLITCH_COUNT = glitch_q;

  generate
    if (PACK == 0) begin : g_single
      logic [WIDTH-1:0] out_q;
      logic             vld_q;

      always_ff @(posedge CLK) begin
        if (RESET) begin
          out_q <= '0;
          vld_q <= 1'b0;
        end else begin
          vld_q <= accept;
          if (accept) out_q <= s;
        end
      end

      assign SYNC_OUT   = out_q;
      assign SYNC_VALID = vld_q;
      assign PHASE      = 1'b0;
    end else begin : g_pack
      typedef enum logic {LOW = 1'b0, HIGH = 1'b1} pack_state_t;
      pack_state_t        state_q;
      logic [WIDTH-1:0]   low_q;
      logic [2*WIDTH-1:0] out_q;
      logic               vld_q;

      always_ff @(posedge CLK) begin
        if (RESET) begin
          state_q <= LOW;
          low_q   <= '0;
          out_q   <= '0;
          vld_q   <= 1'b0;
        end else begin
          vld_q <= 1'b0;
          case (state_q)
            LOW: if (accept) begin
              low_q   <= s;
              state_q <= HIGH;
            end
            HIGH: if (accept) begin
              out_q   <= {s, low_q};
              vld_q   <= 1'b1;
              state_q <= LOW;
            end
            default: state_q <= LOW;
          endcase
        end
      end

      assign SYNC_OUT   = out_q;
      assign SYNC_VALID = vld_q;
      assign PHASE      = (state_q == HIGH);
    end
  endgenerate

endmodule

// File: tb/tb_pack_stable_synchronizer.sv
// Directed bench: single-word latency, glitch rejection, enable gating, packing,
// reset during a pending half, and glitch counter saturation.
module tb_pack_stable_synchronizer;

  localparam int W = 13;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  // dut0: PACK=0 defaults
  logic          rst0, en0, vld0, ph0;
  logic [W-1:0]  in0, out0;
  logic [15:0]   gc0;
  // dut1: PACK=1
  logic          rst1, en1, vld1, ph1;
  logic [W-1:0]  in1;
  logic [2*W-1:0] out1;
  logic [15:0]   gc1;
  // dut2: PACK=0, GLITCH_W=4
  logic          rst2, en2, vld2, ph2;
  logic [W-1:0]  in2, out2;
  logic [3:0]    gc2;

  pack_stable_synchronizer #(.WIDTH(W), .PACK(0)) dut0 (
    .CLK(CLK), .RESET(rst0), .ASYNC_IN(in0), .ENABLE(en0),
    .SYNC_OUT(out0), .SYNC_VALID(vld0), .PHASE(ph0), .GLITCH_COUNT(gc0));

  pack_stable_synchronizer #(.WIDTH(W), .PACK(1)) dut1 (
    .CLK(CLK), .RESET(rst1), .ASYNC_IN(in1), .ENABLE(en1),
    .SYNC_OUT(out1), .SYNC_VALID(vld1), .PHASE(ph1), .GLITCH_COUNT(gc1));

  pack_stable_synchronizer #(.WIDTH(W), .PACK(0), .GLITCH_W(4)) dut2 (
    .CLK(CLK), .RESET(rst2), .ASYNC_IN(in2), .ENABLE(en2),
    .SYNC_OUT(out2), .SYNC_VALID(vld2), .PHASE(ph2), .GLITCH_COUNT(gc2));

  int n_chk  = 0;
  int n_pass = 0;
  int np0 = 0, np1 = 0, np2 = 0;
  logic [2*W-1:0] last0, last1;
  int first_k;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance one clock; sample 1 time unit after the edge and log valid pulses.
  task automatic tick();
    @(posedge CLK);
    #1;
    if (vld0) begin np0++; last0 = {{W{1'b0}}, out0}; end
    if (vld1) begin np1++; last1 = out1; end
    if (vld2) np2++;
  endtask

  initial begin
    rst0 = 1; rst1 = 1; rst2 = 1;
    en0 = 1; en1 = 1; en2 = 1;
    in0 = '0; in1 = '0; in2 = '0;
    last0 = '0; last1 = '0;
    tick(); tick();
    rst0 = 0; rst1 = 0; rst2 = 0;

    chk("rst_out0", {51'd0, out0}, 64'd0);
    chk("rst_vld0", {63'd0, vld0}, 64'd0);
    chk("rst_ph1", {63'd0, ph1}, 64'd0);
    chk("rst_out1", {38'd0, out1}, 64'd0);
    chk("rst_gc0", {48'd0, gc0}, 64'd0);

    // Zero held after reset equals ACC: no acceptance
    for (int k = 0; k < 8; k++) tick();
    chk("idle_pulses", np0, 0);

    // Single word latency
    in0 = 13'h0A5;
    first_k = -1;
    np0 = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (vld0 && first_k < 0) first_k = k;
    end
    chk("lat_edge", first_k, 5);
    chk("lat_pulses", np0, 1);
    chk("lat_out", last0, 26'h0A5);
    chk("lat_gc", {48'd0, gc0}, 64'd0);

    // Return to accepted 0, then a 2-cycle glitch
    in0 = '0;
    for (int k = 0; k < 10; k++) tick();
    chk("zero_out", {51'd0, out0}, 64'd0);
    np0 = 0;
    in0 = 13'h1FFF;
    tick(); tick();
    in0 = '0;
    for (int k = 0; k < 15; k++) tick();
    chk("glitch_pulses", np0, 0);
    chk("glitch_out", {51'd0, out0}, 64'd0);
    chk("glitch_cnt", {48'd0, gc0}, 64'd1);

    // Enable gating
    en0 = 0;
    in0 = 13'h0055;
    for (int k = 0; k < 10; k++) tick();
    chk("gated_pulses", np0, 0);
    en0 = 1;
    tick();
    chk("en_vld", {63'd0, vld0}, 64'd1);
    chk("en_out", {51'd0, out0}, 64'h55);
    tick();
    chk("en_vld_drop", {63'd0, vld0}, 64'd0);
    chk("en_hold", {51'd0, out0}, 64'h55);

    // Packing two words
    in1 = 13'h0123;
    for (int k = 0; k < 10; k++) tick();
    chk("pack_phase_hi", {63'd0, ph1}, 64'd1);
    chk("pack_no_pulse", np1, 0);
    in1 = 13'h0456;
    for (int k = 0; k < 10; k++) tick();
    chk("pack_pulses", np1, 1);
    chk("pack_out", last1, 26'h8AC123);
    chk("pack_phase_lo", {63'd0, ph1}, 64'd0);

    // Reset while first half is pending
    np1 = 0;
    in1 = 13'h0011;
    for (int k = 0; k < 10; k++) tick();
    chk("mid_phase_hi", {63'd0, ph1}, 64'd1);
    rst1 = 1;
    in1 = 13'h0022;
    tick();
    rst1 = 0;
    chk("mid_rst_phase", {63'd0, ph1}, 64'd0);
    chk("mid_rst_out", {38'd0, out1}, 64'd0);
    for (int k = 0; k < 10; k++) tick();
    chk("mid_phase_22", {63'd0, ph1}, 64'd1);
    in1 = 13'h0033;
    for (int k = 0; k < 10; k++) tick();
    chk("mid_pulses", np1, 1);
    chk("mid_out", last1, 26'h66022);
    chk("mid_phase_lo", {63'd0, ph1}, 64'd0);

    // Glitch counter saturation
    for (int i = 0; i < 20; i++) begin
      in2 = (i % 2 == 0) ? 13'h0001 : 13'h0002;
      tick();
      in2 = '0;
      tick(); tick(); tick();
      if (i == 9) chk("sat_mid", {60'd0, gc2}, 64'd10);
    end
    for (int k = 0; k < 5; k++) tick();
    chk("sat_cnt", {60'd0, gc2}, 64'd15);
    chk("sat_pulses", np2, 0);
    chk("sat_phase", {63'd0, ph2}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pack_stable_synchronizer.md
Name: pack_stable_synchronizer

Overview:
- Parametrised successor to the fixed-width bus synchronizers: brings an asynchronous WIDTH-bit bus into the CLK domain through a SYNC_STAGES-deep ASYNC_REG chain.
- Adds bus-coherence qualification: a word is accepted only after it has been stable for STABLE_CYCLES cycles.
- Adds glitch counting and optional packing of two accepted words into one 2*WIDTH output word.
- Sits between slow front-end status/trigger buses and the CLK-domain register/trigger logic.

Parameters:
- WIDTH, 13, bus width in bits (>=1)
- SYNC_STAGES, 2, synchronizer flops per bit (>=2), all marked ASYNC_REG
- STABLE_CYCLES, 3, consecutive equal synchronized samples required before acceptance (>=1)
- PACK, 1, 0 = one word per output; 1 = two accepted words packed per output
- GLITCH_W, 16, width of the saturating glitch counter (>=2)

Ports:
- CLK  in  1  sole clock
- RESET  in  1  synchronous, active-high reset
- ASYNC_IN  in  WIDTH  asynchronous input bus
- ENABLE  in  1  acceptance enable (CLK domain)
- SYNC_OUT  out  (PACK+1)*WIDTH  accepted word(s); with PACK=1 the layout is {second, first}
- SYNC_VALID  out  1  one-cycle pulse when SYNC_OUT is updated
- PHASE  out  1  1 = first half held, waiting for the second half (always 0 when PACK=0)
- GLITCH_COUNT  out  GLITCH_W  saturating count of rejected candidate words

Behaviour:
- Reset (synchronous, active-high):
  - Clears the sync chain, S, P, the stability counter, ACC, the low-half register, SYNC_OUT, SYNC_VALID, PHASE and GLITCH_COUNT to 0.
  - Because ACC=0, an input held at 0 after reset produces no acceptance.
  - Reset mid-operation discards any pending half and any partial stability count.
- Sync chain: per-bit shift chain of SYNC_STAGES flops. S is the chain output; P is S delayed by one cycle.
- Stability counter CNT, range 0..STABLE_CYCLES:
  - S != P sets CNT to 0.
  - Otherwise CNT increments, saturating at STABLE_CYCLES.
- Candidate: the word S while CNT < STABLE_CYCLES and S != ACC.
- Acceptance:
  - Occurs in the cycle where CNT == STABLE_CYCLES, S != ACC and ENABLE = 1.
  - On acceptance, ACC <= S and the word is passed to the packing logic.
  - A word equal to ACC is never re-accepted.
- ENABLE=0:
  - Tracking and CNT continue; acceptance is suppressed; PHASE and the pending half are held.
  - When ENABLE rises with a stable word different from ACC, that word is accepted on the first enabled edge.
- Glitch:
  - A cycle with S != P while P != ACC and CNT < STABLE_CYCLES means a candidate was abandoned.
  - In that cycle GLITCH_COUNT increments, saturating at 2^GLITCH_W-1 with no wrap.
- Latency (PACK=0):
  - Define edge 0 as the first CLK edge that samples a new, steady ASYNC_IN value.
  - SYNC_OUT and SYNC_VALID update at edge SYNC_STAGES+STABLE_CYCLES (edge 5 with defaults), registered.
  - SYNC_VALID is high for exactly one cycle.
- Pack FSM (PACK=1):
  - States LOW (PHASE=0) and HIGH (PHASE=1).
  - LOW + accept: store the word in the low half, go to HIGH, no SYNC_VALID.
  - HIGH + accept: SYNC_OUT <= {word, low half}, SYNC_VALID pulses, go to LOW.
  - Acceptance and reset in the same cycle: reset wins.
- PACK=0: SYNC_OUT <= word and SYNC_VALID pulses on every acceptance; PHASE is tied to 0.
- SYNC_OUT holds its value between pulses.
- Simultaneous glitch and acceptance cannot occur, because acceptance requires S == P.

Test Plan:
- PACK=0, defaults:
  - Stimulus: RESET 2 cycles, then ASYNC_IN 0 -> 0x0A5 held 20 cycles.
  - Response: exactly one SYNC_VALID pulse at edge 5 after the sampling edge, with SYNC_OUT=0x0A5 and GLITCH_COUNT=0.
- Glitch:
  - Stimulus: from accepted 0, ASYNC_IN=0x1FFF for 2 cycles, then 0.
  - Response: no SYNC_VALID, SYNC_OUT stays 0, GLITCH_COUNT=1.
- PACK=1:
  - Stimulus: ASYNC_IN 0x0123 held 10 cycles, then 0x0456 held 10 cycles.
  - Response: PHASE=1 between the two acceptances; a single SYNC_VALID with SYNC_OUT=0x8AC123; PHASE returns to 0.
- ENABLE gating, PACK=0:
  - Stimulus: ENABLE=0, ASYNC_IN -> 0x0055 held 10 cycles, then ENABLE=1.
  - Response: no pulse while ENABLE=0; SYNC_VALID on the first enabled edge with SYNC_OUT=0x0055.
- Saturation, GLITCH_W=4:
  - Stimulus: 20 glitches of 1 cycle each, alternating 0x0001/0x0002 and returning to 0.
  - Response: GLITCH_COUNT=15, held at 15 (no wrap).
- Reset mid-pack, PACK=1:
  - Stimulus: accept 0x0011 (PHASE=1), assert RESET 1 cycle, then present 0x0022 and 0x0033.
  - Response: PHASE=0 after reset; SYNC_VALID with SYNC_OUT={0x0033,0x0022}=0x66022; 0x0011 never appears.
